// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and width helpers for the APB master bridge
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int DEFAULT_ADD_WIDTH = 9;
    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_SEL_BIT   = DEFAULT_ADD_WIDTH - 1;

    // The address MSB picks the responder; everything below it is the word address.
    function automatic int sel_bit(input int add_width);
        return add_width - 1;
    endfunction

    function automatic int strb_width(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - command/response to APB requester for two responders
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADD_WIDTH = 9,
    parameter int WIDTH     = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                        Pclk,
    input  logic                        Presetn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [ADD_WIDTH-1:0]        cmd_addr,
    input  logic [WIDTH-1:0]            cmd_wdata,
    input  logic [strb_width(WIDTH)-1:0] cmd_strb,
    output logic                        rsp_valid,
    output logic [WIDTH-1:0]            rsp_rdata,
    output logic                        rsp_err,
    output logic                        Psel1,
    output logic                        Psel2,
    output logic                        Penable,
    output logic                        Pwrite,
    output logic [ADD_WIDTH-2:0]        Paddr,
    output logic [WIDTH-1:0]            Pwdata,
    output logic [strb_width(WIDTH)-1:0] Pstrb,
    input  logic [WIDTH-1:0]            Prdata1,
    input  logic [WIDTH-1:0]            Prdata2,
    input  logic                        Pready1,
    input  logic                        Pready2
);

    localparam int SEL = sel_bit(ADD_WIDTH);
    localparam int SW  = strb_width(WIDTH);
    localparam int CW  = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    apb_state_e       state_q, state_d;
    logic             psel1_q, psel1_d;
    logic             psel2_q, psel2_d;
    logic             penable_q, penable_d;
    logic             pwrite_q, pwrite_d;
    logic [SEL-1:0]   paddr_q, paddr_d;
    logic [WIDTH-1:0] pwdata_q, pwdata_d;
    logic [SW-1:0]    pstrb_q, pstrb_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CW-1:0]    wait_cnt_q, wait_cnt_d;

    logic             sel_ready;
    logic [WIDTH-1:0] sel_rdata;

    // Only the selected responder is listened to; the other one's Pready is ignored.
    assign sel_ready = psel2_q ? Pready2 : Pready1;
    assign sel_rdata = psel2_q ? Prdata2 : Prdata1;

    assign cmd_ready = (state_q == IDLE) && Presetn;

    always_comb begin
        state_d     = state_q;
        psel1_d     = psel1_q;
        psel2_d     = psel2_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        wait_cnt_d  = wait_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d   = SETUP;
                    psel1_d   = ~cmd_addr[SEL];
                    psel2_d   = cmd_addr[SEL];
                    penable_d = 1'b0;
                    paddr_d   = cmd_addr[SEL-1:0];
                    pwrite_d  = cmd_write;
                    pwdata_d  = cmd_wdata;
                    pstrb_d   = cmd_write ? cmd_strb : '0;
                end
            end
            SETUP: begin
                state_d    = ACCESS;
                penable_d  = 1'b1;
                wait_cnt_d = '0;
            end
            ACCESS: begin
                // A responder that becomes ready on the last allowed cycle still completes cleanly.
                if (sel_ready) begin
                    state_d     = IDLE;
                    psel1_d     = 1'b0;
                    psel2_d     = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
                end else if (wait_cnt_q >= CNT_LAST) begin
                    state_d     = IDLE;
                    psel1_d     = 1'b0;
                    psel2_d     = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                psel1_d   = 1'b0;
                psel2_d   = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            state_q     <= IDLE;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            psel1_q     <= psel1_d;
            psel2_q     <= psel2_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign Psel1     = psel1_q;
    assign Psel2     = psel2_q;
    assign Penable   = penable_q;
    assign Pwrite    = pwrite_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign Pstrb     = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
APB requester that turns a simple command/response interface into APB transfers towards two memory-style responders.
- Bit ADD_WIDTH-1 of the command address selects responder 1 or responder 2.
- The remaining ADD_WIDTH-1 bits are driven on Paddr.
- Handles responder wait states, byte strobes and a wait-state timeout that ends a hung transfer with an error.

Parameters:
- ADD_WIDTH, 9, command address width; the MSB is the responder select, so Paddr is ADD_WIDTH-1 bits.
- WIDTH, 32, data width; strobe width is WIDTH/8.
- TIMEOUT, 16, maximum number of ACCESS cycles before abort; must be at least 1.

Ports:
- Pclk  in  1  clock.
- Presetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted on the edge where cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADD_WIDTH  responder select (MSB) plus word address.
- cmd_wdata  in  WIDTH  write data.
- cmd_strb  in  WIDTH/8  write byte enables.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  timeout error flag; qualified by rsp_valid.
- Psel1, Psel2  out  1 each  responder selects; at most one is high at a time.
- Penable  out  1  APB enable.
- Pwrite  out  1  APB direction.
- Paddr  out  ADD_WIDTH-1  APB word address.
- Pwdata  out  WIDTH  APB write data.
- Pstrb  out  WIDTH/8  APB byte strobes.
- Prdata1, Prdata2  in  WIDTH each  responder read data.
- Pready1, Pready2  in  1 each  responder ready.

Behaviour:
- Reset (asynchronous, Presetn=0):
  - State goes to IDLE immediately.
  - All outputs are 0: Psel1, Psel2, Penable, Pwrite, Paddr, Pwdata, Pstrb, rsp_valid, rsp_rdata, rsp_err.
  - A transfer in flight is dropped with no response.
  - cmd_ready is 0 while reset is asserted.
- States: IDLE, SETUP, ACCESS.
- cmd_ready = (state == IDLE), combinational.
- All APB and response outputs are registered.
- IDLE -> SETUP on cmd_valid, with these values captured on the accept edge:
  - Psel1 = ~cmd_addr[MSB]; Psel2 = cmd_addr[MSB].
  - Paddr = cmd_addr[ADD_WIDTH-2:0].
  - Pwrite = cmd_write; Pwdata = cmd_wdata.
  - Pstrb = cmd_strb for writes, all-zero for reads.
  - Penable = 0.
- SETUP lasts exactly 1 cycle. Then ACCESS: Penable = 1 and the wait counter clears to 0.
- ACCESS: Paddr, Pwrite, Pwdata, Pstrb and Psel stay stable.
  - Only the selected responder's Pready and Prdata are observed; the unselected Pready is ignored even if high.
- Completion: on the edge where the selected Pready = 1:
  - Psel and Penable return to 0; state goes to IDLE.
  - rsp_valid = 1 for the following cycle, with rsp_err = 0.
  - rsp_rdata = selected Prdata for reads, 0 for writes.
- Timeout: the wait counter counts ACCESS cycles. If the counter reaches TIMEOUT-1 with Pready still low:
  - Transfer terminates: Psel and Penable go to 0.
  - rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
  - If Pready is high in that same cycle, normal completion wins (rsp_err = 0).
- rsp_valid is 0 in all other cycles and rsp_rdata/rsp_err return to 0.
- rsp_valid has no back-pressure.
- Minimum transfer is 3 cycles: SETUP, one ACCESS cycle, then IDLE.
  - A new command can be accepted in the IDLE cycle in which rsp_valid is high.
  - Psel therefore deasserts for at least 1 cycle between transfers.
- In IDLE, Paddr, Pwrite, Pwdata and Pstrb hold their last values.
- Responder wait state: a responder that asserts Pready on its 4th consecutive Psel&&Penable cycle gives 4 ACCESS cycles.
  - Accept to rsp_valid is then 6 cycles.
- Widths: wait counter is clog2(TIMEOUT)+1 bits and saturates; no wrap.

Decomposition:
- Package apb_pkg holds the state enum (IDLE/SETUP/ACCESS), the select-bit index localparam (ADD_WIDTH-1) and the strobe-width expression.
- No sub-module; flat FSM plus wait counter.

Test Plan:
- Write to responder 1:
  - Stimulus: cmd_addr=0x005, wdata=0xDEADBEEF, strb=4'hF.
  - Required: Psel1=1, Paddr=0x05, Pstrb=F; Penable rises 1 cycle after Psel1; rsp_valid 6 cycles after accept with err=0, rdata=0.
- Read back from responder 1:
  - Stimulus: read from 0x005.
  - Required: rsp_rdata=0xDEADBEEF; Pstrb=0 throughout.
- Partial write then read on responder 2:
  - Stimulus: write 0x11223344 with strb=F to address 0x105, then write 0xAABBCCDD with strb=4'b0101.
  - Required: Psel2=1 and Paddr=0x05 on both writes; read of 0x105 returns 0x11BB33DD.
- Timeout:
  - Stimulus: TIMEOUT=16, Pready1 held 0.
  - Required: Psel1 drops after 16 ACCESS cycles; rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - Variant: Pready1 first asserted in ACCESS cycle 16 -> err=0.
- Back-to-back and reset:
  - Stimulus: cmd_valid held high for 3 commands.
  - Required: each accepted only in IDLE; Psel low for at least 1 cycle between transfers; unselected Pready2=1 does not end a responder-1 transfer.
  - Stimulus: Presetn pulsed low mid-ACCESS.
  - Required: all outputs 0 immediately, no rsp_valid, next command runs normally.
